// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO write port.
// Build option MULDIV_ABORT_EN adds i_abort to cancel an operation in CALC or FIX.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    input  logic [WIDTH-1:0] i_mt_data,
    input  logic             i_hilo_rd,
`ifdef MULDIV_ABORT_EN
    input  logic             i_abort,
`endif
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_hi_wr,
    output logic             o_lo_wr,
    output logic [WIDTH-1:0] o_hi_din,
    output logic [WIDTH-1:0] o_lo_din,
    output logic             o_done
);
    // state | meaning
    // IDLE  | ready; MTHI/MTLO pass through, start launches an operation
    // CALC  | WIDTH shift-add or restoring-divide iterations
    // FIX   | sign correction of product or quotient/remainder
    // WB    | write HI/LO and pulse done
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_WB} state_t;

    localparam int CW = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sa;
    logic               r_sb;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_abort;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;

`ifdef MULDIV_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_a_abs  = (!i_op[0] && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_abs  = (!i_op[0] && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_msum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};

    assign o_busy  = (r_state != S_IDLE);
    assign o_stall = o_busy & (i_start | i_hilo_rd | i_mthi | i_mtlo);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        o_hi_wr  = 1'b0;
        o_lo_wr  = 1'b0;
        o_hi_din = '0;
        o_lo_din = '0;
        o_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_CALC;
                o_hi_wr = i_mthi & i_rst_n;
                o_lo_wr = i_mtlo & i_rst_n;
                if (o_hi_wr) o_hi_din = i_mt_data;
                if (o_lo_wr) o_lo_din = i_mt_data;
            end
            S_CALC: begin
                if (w_abort)                         w_next = S_IDLE;
                else if (r_cnt == CW'(WIDTH - 1))    w_next = S_FIX;
            end
            S_FIX: w_next = w_abort ? S_IDLE : S_WB;
            S_WB: begin
                w_next   = S_IDLE;
                o_hi_wr  = 1'b1;
                o_lo_wr  = 1'b1;
                o_done   = 1'b1;
                o_hi_din = r_acc[2*WIDTH-1:WIDTH];
                o_lo_din = r_acc[WIDTH-1:0];
            end
            default: w_next = S_IDLE;
        endcase
    end

    // r_acc holds {upper, lower} product for multiply and {remainder, quotient} for divide
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_cnt <= '0;
            r_acc <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_op  <= i_op;
                    r_a   <= w_a_abs;
                    r_b   <= w_b_abs;
                    r_sa  <= i_a[WIDTH-1];
                    r_sb  <= i_b[WIDTH-1];
                    r_cnt <= '0;
                    r_acc <= {{WIDTH{1'b0}}, (i_op[1] ? w_a_abs : w_b_abs)};
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!r_op[1])
                        r_acc <= {w_msum, r_acc[WIDTH-1:1]};
                    else if (!w_diff[WIDTH])
                        r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                    else
                        r_acc <= {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                end
                S_FIX: begin
                    if (!r_op[1]) begin
                        if (!r_op[0] && (r_sa ^ r_sb)) r_acc <= -r_acc;
                    end else begin
                        // divide by zero keeps the all-ones quotient unsigned
                        if (!r_op[0] && (r_sa ^ r_sb) && (r_b != '0))
                            r_acc[WIDTH-1:0] <= -r_acc[WIDTH-1:0];
                        if (!r_op[0] && r_sa)
                            r_acc[2*WIDTH-1:WIDTH] <= -r_acc[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: arithmetic results, latency, hazards, MT pass-through, reset.
module tb_muldiv_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] mt_data = '0;
    logic         hilo_rd = 1'b0;
`ifdef MULDIV_ABORT_EN
    logic         abort = 1'b0;
`endif
    logic         busy, stall, hi_wr, lo_wr, done;
    logic [W-1:0] hi_din, lo_din;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
        .i_a(a), .i_b(b), .i_mthi(mthi), .i_mtlo(mtlo), .i_mt_data(mt_data),
        .i_hilo_rd(hilo_rd),
`ifdef MULDIV_ABORT_EN
        .i_abort(abort),
`endif
        .o_busy(busy), .o_stall(stall), .o_hi_wr(hi_wr), .o_lo_wr(lo_wr),
        .o_hi_din(hi_din), .o_lo_din(lo_din), .o_done(done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode: 0 plain, 1 hilo_rd held, 2 start during CALC, 3 mtlo during CALC, 4 mthi at launch
    task automatic run_op(input string tag, input logic [1:0] t_op, input logic [W-1:0] t_a,
                          input logic [W-1:0] t_b, input logic [W-1:0] e_hi,
                          input logic [W-1:0] e_lo, input int mode);
        int n_busy_err = 0;
        int n_stall_err = 0;
        int n_wr = 0;
        int n_done = 0;
        logic [W-1:0] g_hi = '0;
        logic [W-1:0] g_lo = '0;
        logic exp_busy;
        logic exp_stall;
        logic hold;
        @(negedge clk);
        op = t_op; a = t_a; b = t_b; start = 1'b1;
        mthi = (mode == 4); mt_data = 32'h0BAD_F00D;
        #1;
        if (mode == 4) check({tag, "_mt_launch"}, {hi_wr, lo_wr, hi_din}, {2'b10, 32'h0BAD_F00D});
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        for (int i = 0; i < 35; i++) begin
            hold = (i >= 3) && (i <= 6);
            hilo_rd = (mode == 1);
            start   = (mode == 2) && hold;
            mtlo    = (mode == 3) && hold;
            mt_data = 32'hDEAD_BEEF;
            #1;
            exp_busy  = (i < 34);
            exp_stall = exp_busy && ((mode == 1) || ((mode == 2 || mode == 3) && hold));
            if (busy !== exp_busy) n_busy_err++;
            if (stall !== exp_stall) n_stall_err++;
            if (hi_wr || lo_wr) n_wr++;
            if (hi_wr && lo_wr) begin g_hi = hi_din; g_lo = lo_din; end
            if (done) n_done++;
            @(negedge clk);
        end
        hilo_rd = 1'b0; start = 1'b0; mtlo = 1'b0;
        check({tag, "_busy"}, n_busy_err, 0);
        check({tag, "_stall"}, n_stall_err, 0);
        check({tag, "_writes"}, n_wr, 1);
        check({tag, "_done"}, n_done, 1);
        check({tag, "_hi"}, g_hi, e_hi);
        check({tag, "_lo"}, g_lo, e_lo);
    endtask

    initial begin
        int n_wr;
        int n_busy;
        #2;
        check("rst_ctl", {busy, stall, hi_wr, lo_wr, done}, 5'b0);
        check("rst_din", {hi_din, lo_din}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 2);
        run_op("divu_zero", 2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 3);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0);
        run_op("div_negb",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0);
        run_op("div_zero",  2'b10, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF, 0);
        run_op("multu_mt",  2'b01, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780, 4);

        @(negedge clk);
        mthi = 1'b1; mt_data = 32'h1234_5678;
        #1;
        check("mthi_ctl", {hi_wr, lo_wr, busy, stall}, 4'b1000);
        check("mthi_din", hi_din, 32'h1234_5678);
        mthi = 1'b0; mtlo = 1'b1; mt_data = 32'hCAFE_F00D;
        #1;
        check("mtlo", {hi_wr, lo_wr, lo_din}, {2'b01, 32'hCAFE_F00D});
        mthi = 1'b1; mt_data = 32'h5555_AAAA;
        #1;
        check("mt_both", {hi_wr, lo_wr, hi_din, lo_din}, {2'b11, 32'h5555_AAAA, 32'h5555_AAAA});
        mthi = 1'b0; mtlo = 1'b0;

        @(negedge clk);
        op = 2'b10; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ctl", {busy, stall, hi_wr, lo_wr, done}, 5'b0);
        check("rst_mid_din", {hi_din, lo_din}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        n_wr = 0; n_busy = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (hi_wr || lo_wr || done) n_wr++;
            if (busy) n_busy++;
            @(negedge clk);
        end
        check("rst_mid_nowr", n_wr, 0);
        check("rst_mid_idle", n_busy, 0);

`ifdef MULDIV_ABORT_EN
        @(negedge clk);
        op = 2'b11; a = 32'd50; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_wr = 0;
        for (int i = 0; i < 40; i++) begin
            abort = (i == 5);
            #1;
            if (i == 5) check("abort_busy_before", busy, 1'b1);
            if (i == 6) check("abort_busy_after", busy, 1'b0);
            if (hi_wr || lo_wr || done) n_wr++;
            @(negedge clk);
        end
        abort = 1'b0;
        check("abort_nowr", n_wr, 0);
        run_op("after_abort", 2'b11, 32'd50, 32'd5, 32'd0, 32'd10, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU from the execute stage and computes over 32 iteration cycles.
- Drives the write strobes and data of the HI and LO registers, and muxes MTHI/MTLO writes onto the same strobes.
- Raises a stall to the pipeline on any HI/LO hazard while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- mthi  input  1  MTHI request.
- mtlo  input  1  MTLO request.
- mt_data  input  WIDTH  MTHI/MTLO data.
- hilo_rd  input  1  MFHI/MFLO in execute stage.
- busy  output  1  operation in flight.
- stall  output  1  pipeline stall request.
- hi_wr  output  1  HI write enable.
- lo_wr  output  1  LO write enable.
- hi_din  output  WIDTH  HI write data.
- lo_din  output  WIDTH  LO write data.
- done  output  1  one-cycle pulse coincident with the result write.

Behaviour:
- States: IDLE, CALC, FIX, WB. State is registered. busy = (state != IDLE).
- Reset (rst_n low, asynchronous):
  - state=IDLE, iteration counter=0, accumulators=0.
  - busy=0, stall=0, hi_wr=0, lo_wr=0, done=0, hi_din=0, lo_din=0.
  - Reset mid-operation discards the operation; HI/LO are not written.
- IDLE:
  - start=1 latches op, |a| and |b| (signed ops take absolute values; unsigned ops use raw values) and both sign bits.
  - Counter clears; next state is CALC.
- CALC: exactly WIDTH cycles; counter increments each edge.
  - Multiply: shift-add over a 2*WIDTH product.
  - Divide: restoring divide, one quotient bit per cycle.
  - After count WIDTH-1, next state is FIX.
- FIX: one cycle of sign correction.
  - MULT: negate the product if sign(a) xor sign(b).
  - DIV: quotient is negated if the signs differ; remainder takes the sign of a.
- WB: one cycle.
  - hi_wr=lo_wr=1 and done=1.
  - hi_din = product[2W-1:W] or remainder; lo_din = product[W-1:0] or quotient.
  - Next state is IDLE.
- Latency: start sampled at edge E0 → busy high for WIDTH+2 cycles → HI/LO updated at edge E0+WIDTH+2.
- Divide by zero: completes with normal latency; HI=a (original value), LO=all ones.
- DIV with a=0x80000000, b=0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO:
  - In IDLE, combinational pass-through with zero latency: mthi gives hi_wr=1, hi_din=mt_data; mtlo gives lo_wr=1, lo_din=mt_data.
  - mthi and mtlo together write both registers.
  - start in the same IDLE cycle as mthi/mtlo: the MT write happens now and the operation launches.
- stall = busy & (start | hilo_rd | mthi | mtlo), combinational.
  - While busy, start/mthi/mtlo are ignored; the pipeline holds them until busy falls.
  - No stall in IDLE.
- Write strobes are never asserted in CALC or FIX.

Optional Feature:
- Macro: MULDIV_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in CALC or FIX returns the block to IDLE at the next edge with no HI/LO write and no done pulse.
  - abort in WB is ignored; the write completes.
  - abort in IDLE has no effect, and start is still honoured in that cycle.
- Undefined: no abort port; every operation runs to WB.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 34 busy cycles, hi_wr/lo_wr pulse once; HI=0xFFFFFFFE, LO=0x00000001; done for 1 cycle.
- MULT a=-3 (0xFFFFFFFD), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV a=-7, b=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=100, b=0 → LO=0xFFFFFFFF, HI=100.
- Hazards: hilo_rd=1 while busy → stall=1 every cycle until busy falls, then stall=0. start asserted during CALC → ignored, stall=1, exactly one result write.
- MTHI 0x12345678 in IDLE → same-cycle hi_wr=1, hi_din=0x12345678, lo_wr=0. MTLO during CALC → lo_wr stays 0, stall=1.
- rst_n pulsed low at iteration 10 of a DIV → outputs zero immediately, state IDLE, no WB write. With MULDIV_ABORT_EN, abort at iteration 5 → IDLE next edge, no done.
